i2s_tx: RTL

Serial audio transmitter for the pedal's output DAC, the counterpart of the I2S receiver. It accepts stereo sample pairs on an AXI-stream slave port and serialises them as Philips-format I2S. It is the bus clock master: sclk and lrck are generated from the single system clock `clk` (the codec mclk domain). A one-entry holding register decouples the effect pipeline from frame timing, and the block substitutes silence on underrun.

---
 rtl/i2s_tx_if.sv | 28 ++
 rtl/i2s_tx.sv | 138 +++++++++++++
 2 files changed

// File: rtl/i2s_tx_if.sv
// ============================================================================
// Module   : axis_if
// Purpose  : AXI-stream style sample channel carrying one stereo pair per beat.
// Ports    : vld   - master asserts when data holds a valid pair
//            ok    - slave ready; a beat transfers when vld & ok
//            data  - packed pair {lc, rc}, each DATA_WIDTH bits, signed,
//                    right-aligned
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface axis_if #(
  parameter int DATA_WIDTH = 24
);
  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] lc;
    logic signed [DATA_WIDTH-1:0] rc;
  } sample_t;

  logic    vld;
  logic    ok;
  sample_t data;

  modport master (output vld, output data, input ok);
  modport slave  (input vld, input data, output ok);
endinterface

`default_nettype wire

// File: rtl/i2s_tx.sv
// ============================================================================
// Module   : i2s_tx
// Purpose  : I2S serial audio transmitter and bus-clock master. Stereo pairs
//            arrive on an AXI-stream slave port into a one-entry holding
//            register and are serialised one pair per 64-sclk frame, MSB
//            first in 32-bit slots. Silence is sent when no pair is waiting.
// Ports    : clk       - system / codec mclk clock, rising edge
//            rst       - asynchronous active-low reset (released synchronously
//                        to clk upstream)
//            axis_tx   - sample input (axis_if.slave)
//            sclk      - bit clock, clk / CLK_DIV
//            lrck      - word select, 0 = left slot, 1 = right slot
//            sdo       - serial data out
//            underrun  - one-clk pulse during a load cycle with no sample
// Config   : I2S_TX_LEFT_JUSTIFIED_EN - when defined, left-justified format
//            (no one-bit delay after the lrck edge) instead of Philips I2S.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module i2s_tx #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 24
) (
  input  logic   clk,
  input  logic   rst,
  axis_if.slave  axis_tx,
  output logic   sclk,
  output logic   lrck,
  output logic   sdo,
  output logic   underrun
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int PAD   = 32 - DATA_WIDTH;

  // div_cnt values at which the next clk edge is an sclk fall / rise, and
  // the cycle just before a load cycle.
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

  logic [DIV_W-1:0]      div_cnt;
  logic [5:0]            bcnt;
  logic                  full;
  logic                  ok_q;
  logic [DATA_WIDTH-1:0] hold_lc;
  logic [DATA_WIDTH-1:0] hold_rc;
  logic [63:0]           frame_sr;

  logic                  fall_edge;
  logic                  rise_edge;
  logic                  load;
  logic                  pre_load;
  logic                  accept;
  logic                  full_next;
  logic [5:0]            bcnt_next;
  logic [63:0]           hold_frame;
  logic [63:0]           frame_next;
  logic                  sdo_bit;

  // Places a right-aligned sample at the top of a 32-bit slot, zero padded.
  function automatic logic [31:0] slot(input logic [DATA_WIDTH-1:0] s);
    slot = 32'(s) << PAD;
  endfunction

  assign axis_tx.ok = ok_q;

  assign fall_edge  = (div_cnt == DIV_LAST);
  assign rise_edge  = (div_cnt == DIV_RISE);
  assign load       = fall_edge && (bcnt == 6'd63);
  assign pre_load   = (div_cnt == DIV_PRE) && (bcnt == 6'd63);
  assign accept     = axis_tx.vld && ok_q;
  assign bcnt_next  = bcnt + 6'd1;
  assign hold_frame = {slot(hold_lc), slot(hold_rc)};

  // Accept can only happen while full is clear, so it takes priority over
  // the clear done by a load; a pair accepted in the load cycle itself
  // therefore waits in holding for the following frame.
  assign full_next  = accept ? 1'b1 : (load ? 1'b0 : full);

  assign frame_next = load ? (full ? hold_frame : 64'd0) : frame_sr;

  // The bit presented after this sclk fall belongs to bcnt_next. Using
  // frame_next lets the wrap edge see the freshly loaded frame.
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  assign sdo_bit = frame_next[~bcnt_next];
`else
  // One-sclk I2S delay: slot MSBs appear one bit after the lrck edge;
  // 0 - bcnt_next is 64 - bcnt_next in 6-bit arithmetic.
  assign sdo_bit = (bcnt_next == 6'd0) ? 1'b0 : frame_next[6'd0 - bcnt_next];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      bcnt     <= '0;
      full     <= 1'b0;
      ok_q     <= 1'b0;
      hold_lc  <= '0;
      hold_rc  <= '0;
      frame_sr <= '0;
      sclk     <= 1'b0;
      lrck     <= 1'b0;
      sdo      <= 1'b0;
      underrun <= 1'b0;
    end else begin
      div_cnt  <= fall_edge ? '0 : div_cnt + 1'b1;
      frame_sr <= frame_next;
      full     <= full_next;
      // ok mirrors the complement of full one cycle ahead so that it is
      // never high while the holding register is occupied.
      ok_q     <= ~full_next;
      // Registered one cycle early so the pulse sits in the load cycle and
      // reflects the full flag that cycle will see.
      underrun <= pre_load && !full_next;

      if (accept) begin
        hold_lc <= axis_tx.data.lc;
        hold_rc <= axis_tx.data.rc;
      end

      if (rise_edge) begin
        sclk <= 1'b1;
      end

      if (fall_edge) begin
        sclk <= 1'b0;
        bcnt <= bcnt_next;
        lrck <= bcnt_next[5];
        sdo  <= sdo_bit;
      end
    end
  end

endmodule

`default_nettype wire
